// File: rtl/iddmm_result_sel.sv
// Final-correction stage: buffers the raw (u) and subtracted (u-p) result streams of one
// Montgomery product, then streams the stream chosen by cal_sign over a valid/ready port.
module iddmm_result_sel #(
    parameter int K     = 128,
    parameter int N     = 32,
    parameter int CNT_W = $clog2(N) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             fifo_wr_en_a,
    input  logic [K-1:0]     fifo_wr_data_a,
    input  logic             fifo_wr_en_sub,
    input  logic [K-1:0]     fifo_wr_data_sub,
    input  logic             cal_done,
    input  logic             cal_sign,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [K-1:0]     o_data,
    output logic [CNT_W-2:0] o_idx,
    output logic             o_last,
    output logic             res_sel,
    output logic             res_done,
    output logic             busy,
    output logic             err_ovf
);

    typedef enum logic {S_COLLECT, S_SEND} state_t;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);
    localparam logic [CNT_W-2:0] RD_LAST  = (CNT_W-1)'(N - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]   cnt_s_q, cnt_s_d;
    logic [CNT_W-2:0]   rd_q, rd_d;
    logic               done_seen_q, done_seen_d;
    logic               res_sel_q, res_sel_d;
    logic               res_done_q, res_done_d;
    logic               err_ovf_q, err_ovf_d;
    logic               wr_a, wr_s;
    logic               complete;
    logic [K-1:0]       buf_a [N];
    logic [K-1:0]       buf_s [N];

    // Completion uses registered counters so the last word and cal_done may arrive in any order.
    assign complete = (cnt_a_q == CNT_FULL) && (cnt_s_q == CNT_FULL) && done_seen_q;

    always_comb begin
        state_d     = state_q;
        cnt_a_d     = cnt_a_q;
        cnt_s_d     = cnt_s_q;
        rd_d        = rd_q;
        done_seen_d = done_seen_q;
        res_sel_d   = res_sel_q;
        res_done_d  = 1'b0;
        err_ovf_d   = err_ovf_q;
        wr_a        = 1'b0;
        wr_s        = 1'b0;
        case (state_q)
            S_COLLECT: begin
                if (fifo_wr_en_a) begin
                    if (cnt_a_q != CNT_FULL) begin
                        wr_a    = 1'b1;
                        cnt_a_d = cnt_a_q + 1'b1;
                    end else begin
                        err_ovf_d = 1'b1;
                    end
                end
                if (fifo_wr_en_sub) begin
                    if (cnt_s_q != CNT_FULL) begin
                        wr_s    = 1'b1;
                        cnt_s_d = cnt_s_q + 1'b1;
                    end else begin
                        err_ovf_d = 1'b1;
                    end
                end
                if (cal_done) begin
                    if (!done_seen_q) begin
                        res_sel_d   = cal_sign;
                        done_seen_d = 1'b1;
                    end else begin
                        err_ovf_d = 1'b1;
                    end
                end
                if (complete) begin
                    state_d = S_SEND;
                    rd_d    = '0;
                end
            end
            S_SEND: begin
                if (fifo_wr_en_a || fifo_wr_en_sub || cal_done) begin
                    err_ovf_d = 1'b1;
                end
                if (o_ready) begin
                    if (rd_q == RD_LAST) begin
                        state_d     = S_COLLECT;
                        res_done_d  = 1'b1;
                        cnt_a_d     = '0;
                        cnt_s_d     = '0;
                        done_seen_d = 1'b0;
                        rd_d        = '0;
                    end else begin
                        rd_d = rd_q + 1'b1;
                    end
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_COLLECT;
            cnt_a_q     <= '0;
            cnt_s_q     <= '0;
            rd_q        <= '0;
            done_seen_q <= 1'b0;
            res_sel_q   <= 1'b0;
            res_done_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else if (i_clr) begin
            state_q     <= S_COLLECT;
            cnt_a_q     <= '0;
            cnt_s_q     <= '0;
            rd_q        <= '0;
            done_seen_q <= 1'b0;
            res_sel_q   <= 1'b0;
            res_done_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_a_q     <= cnt_a_d;
            cnt_s_q     <= cnt_s_d;
            rd_q        <= rd_d;
            done_seen_q <= done_seen_d;
            res_sel_q   <= res_sel_d;
            res_done_q  <= res_done_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    // Word storage needs no reset: nothing reaches o_data outside S_SEND.
    always_ff @(posedge clk) begin
        if (wr_a) buf_a[cnt_a_q[CNT_W-2:0]] <= fifo_wr_data_a;
        if (wr_s) buf_s[cnt_s_q[CNT_W-2:0]] <= fifo_wr_data_sub;
    end

    assign o_valid  = (state_q == S_SEND);
    assign busy     = o_valid;
    assign o_data   = o_valid ? (res_sel_q ? buf_s[rd_q] : buf_a[rd_q]) : '0;
    assign o_idx    = o_valid ? rd_q : '0;
    assign o_last   = o_valid && (rd_q == RD_LAST);
    assign res_sel  = res_sel_q;
    assign res_done = res_done_q;
    assign err_ovf  = err_ovf_q;

endmodule
